// File: rtl/btb_predictor.sv
// Branch target buffer with saturating-counter direction prediction, bimodal or gshare indexed.
// Lookup is combinational (zero latency); updates land next cycle; no backpressure, one update per cycle.
module btb_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8,
  parameter int MODE     = 0,
  localparam int IDX     = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_fetch,
  output logic                predict_taken,
  output logic [XLEN-1:0]     predict_target,
  output logic [CTR_BITS-1:0] predict_state,
  output logic [IDX-1:0]      predict_ghr,
  input  logic                update_en,
  input  logic [XLEN-1:0]     resolved_pc,
  input  logic                resolved_taken,
  input  logic [XLEN-1:0]     resolved_target,
  input  logic [IDX-1:0]      resolved_ghr,
  input  logic                clear
);

  localparam logic [CTR_BITS-1:0] WT      = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] WNT     = ~WT;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t              tbl [ENTRIES];
  logic [IDX-1:0]      ghr;

  logic [IDX-1:0]      idx_f;
  logic [IDX-1:0]      idx_u;
  logic [TAG_BITS-1:0] tag_f;
  logic [TAG_BITS-1:0] tag_u;
  entry_t              ent_f;
  logic                hit_f;
  logic                hit_u;
  logic [CTR_BITS-1:0] ctr_u;
  logic [CTR_BITS-1:0] ctr_nxt;
  logic                unused_bits;

  // Fetch side: index folds in the live ghr in gshare mode.
  assign idx_f = pc_fetch[IDX+1:2] ^ ((MODE == 1) ? ghr : '0);
  assign tag_f = pc_fetch[IDX+TAG_BITS+1:IDX+2];
  assign ent_f = tbl[idx_f];
  assign hit_f = ent_f.valid && (ent_f.tag == tag_f);

  assign predict_taken  = hit_f && ent_f.ctr[CTR_BITS-1];
  assign predict_target = predict_taken ? ent_f.target : pc_fetch + XLEN'(4);
  assign predict_state  = hit_f ? ent_f.ctr : WNT;
  assign predict_ghr    = ghr;

  // Update side must reproduce the fetch-time index, so it uses the carried ghr.
  assign idx_u = resolved_pc[IDX+1:2] ^ ((MODE == 1) ? resolved_ghr : '0);
  assign tag_u = resolved_pc[IDX+TAG_BITS+1:IDX+2];
  assign hit_u = tbl[idx_u].valid && (tbl[idx_u].tag == tag_u);
  assign ctr_u = tbl[idx_u].ctr;

  assign unused_bits = ^{resolved_pc, resolved_ghr};

  always_comb begin
    ctr_nxt = ctr_u;
    if (resolved_taken) begin
      if (ctr_u != CTR_MAX) ctr_nxt = ctr_u + CTR_BITS'(1);
    end else begin
      if (ctr_u != '0) ctr_nxt = ctr_u - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
      ghr <= '0;
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
      end
      ghr <= '0;
    end else if (update_en) begin
      if (hit_u) begin
        tbl[idx_u].ctr <= ctr_nxt;
        if (resolved_taken) tbl[idx_u].target <= resolved_target;
      end else if (resolved_taken) begin
        tbl[idx_u] <= '{valid: 1'b1, tag: tag_u, target: resolved_target, ctr: WT};
      end
      if (MODE == 1) ghr <= {ghr[IDX-2:0], resolved_taken};
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench: bimodal and gshare instances share stimulus; a table model supplies expectations.
module tb_btb_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, clear = 1'b0, update_en = 1'b0, resolved_taken = 1'b0, look_vld = 1'b0;
  logic [31:0] pc_fetch = '0, resolved_pc = '0, resolved_target = '0;
  logic [3:0]  rghr0 = '0, rghr1 = '0;

  logic        pt0, pt1;
  logic [31:0] ptg0, ptg1;
  logic [1:0]  ps0, ps1;
  logic [3:0]  pg0, pg1;

  btb_predictor #(.MODE(0)) u_bim (
    .clk(clk), .rst(rst), .pc_fetch(pc_fetch),
    .predict_taken(pt0), .predict_target(ptg0), .predict_state(ps0), .predict_ghr(pg0),
    .update_en(update_en), .resolved_pc(resolved_pc), .resolved_taken(resolved_taken),
    .resolved_target(resolved_target), .resolved_ghr(rghr0), .clear(clear)
  );

  btb_predictor #(.MODE(1)) u_gsh (
    .clk(clk), .rst(rst), .pc_fetch(pc_fetch),
    .predict_taken(pt1), .predict_target(ptg1), .predict_state(ps1), .predict_ghr(pg1),
    .update_en(update_en), .resolved_pc(resolved_pc), .resolved_taken(resolved_taken),
    .resolved_target(resolved_target), .resolved_ghr(rghr1), .clear(clear)
  );

  typedef struct packed {
    int          id;
    logic        t0;
    logic [31:0] tg0;
    logic [1:0]  s0;
    logic [3:0]  g0;
    logic        t1;
    logic [31:0] tg1;
    logic [1:0]  s1;
    logic [3:0]  g1;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   step_id = 0;

  // Reference model: per-mode table of plain ints, counters 0..3 (WNT=1, WT=2).
  bit          mv   [2][16];
  int          mtag [2][16];
  logic [31:0] mtgt [2][16];
  int          mctr [2][16];
  int          mghr [2];

  function automatic int midx(input int m, input logic [31:0] pc, input int g);
    return int'((pc >> 2) & 32'hF) ^ ((m == 1) ? g : 0);
  endfunction

  function automatic int mtagof(input logic [31:0] pc);
    return int'((pc >> 6) & 32'hFF);
  endfunction

  function automatic void look(input int m, input logic [31:0] pc, output logic t,
                               output logic [31:0] tg, output logic [1:0] st, output logic [3:0] gh);
    int  i;
    bit  hit;
    i   = midx(m, pc, mghr[m]);
    hit = mv[m][i] && (mtag[m][i] == mtagof(pc));
    t   = hit && (mctr[m][i] >= 2);
    tg  = t ? mtgt[m][i] : pc + 32'd4;
    st  = hit ? 2'(mctr[m][i]) : 2'd1;
    gh  = 4'(mghr[m]);
  endfunction

  task automatic model_step();
    int i, t, g;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int e = 0; e < 16; e++) begin
          mv[m][e] = 0; mctr[m][e] = 1;
        end
        mghr[m] = 0;
      end
    end else if (clear) begin
      for (int m = 0; m < 2; m++) begin
        for (int e = 0; e < 16; e++) mv[m][e] = 0;
        mghr[m] = 0;
      end
    end else if (update_en) begin
      for (int m = 0; m < 2; m++) begin
        g = (m == 1) ? int'(rghr1) : 0;
        i = midx(m, resolved_pc, g);
        t = mtagof(resolved_pc);
        if (mv[m][i] && mtag[m][i] == t) begin
          if (resolved_taken) begin
            mctr[m][i] = (mctr[m][i] == 3) ? 3 : mctr[m][i] + 1;
            mtgt[m][i] = resolved_target;
          end else begin
            mctr[m][i] = (mctr[m][i] == 0) ? 0 : mctr[m][i] - 1;
          end
        end else if (resolved_taken) begin
          mv[m][i] = 1; mtag[m][i] = t; mtgt[m][i] = resolved_target; mctr[m][i] = 2;
        end
        if (m == 1) mghr[1] = ((mghr[1] << 1) | int'(resolved_taken)) & 15;
      end
    end
  endtask

  // One clock of stimulus; lsel 0/1 replaces that instance's expectation with literal values.
  task automatic cyc(input bit chk, input int lsel, input logic lt, input logic [31:0] ltg,
                     input logic [1:0] ls, input logic [3:0] lg);
    exp_t e;
    step_id++;
    e.id = step_id;
    look(0, pc_fetch, e.t0, e.tg0, e.s0, e.g0);
    look(1, pc_fetch, e.t1, e.tg1, e.s1, e.g1);
    if (lsel == 0) begin
      e.t0 = lt; e.tg0 = ltg; e.s0 = ls; e.g0 = lg;
    end else if (lsel == 1) begin
      e.t1 = lt; e.tg1 = ltg; e.s1 = ls; e.g1 = lg;
    end
    if (chk) sb.push_back(e);
    look_vld = chk;
    model_step();
    @(posedge clk);
    #1;
    look_vld = 1'b0; rst = 1'b0; clear = 1'b0; update_en = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic [3:0] g1);
    update_en = 1'b1; resolved_pc = pc; resolved_taken = tk; resolved_target = tg;
    rghr1 = g1; rghr0 = 4'($urandom);
  endtask

  task automatic lit0(input logic t, input logic [31:0] tg, input logic [1:0] s);
    cyc(1'b1, 0, t, tg, s, 4'd0);
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (look_vld) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard_underflow step %0d: got empty expected entry", step_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("taken_bim",  e.id, 32'(pt0),  32'(e.t0));
        chk("target_bim", e.id, ptg0,      e.tg0);
        chk("state_bim",  e.id, 32'(ps0),  32'(e.s0));
        chk("ghr_bim",    e.id, 32'(pg0),  32'(e.g0));
        chk("taken_gsh",  e.id, 32'(pt1),  32'(e.t1));
        chk("target_gsh", e.id, ptg1,      e.tg1);
        chk("state_gsh",  e.id, 32'(ps1),  32'(e.s1));
        chk("ghr_gsh",    e.id, 32'(pg1),  32'(e.g1));
      end
    end
  end

  initial begin
    #1;
    rst = 1'b1; cyc(1'b0, -1, 0, 0, 0, 0);
    rst = 1'b1; cyc(1'b0, -1, 0, 0, 0, 0);

    // Reset state, then training and saturation at 0x100 (index 0, tag 4).
    pc_fetch = 32'h100; lit0(0, 32'h104, 2'd1);
    upd(32'h100, 1, 32'h200, 0); lit0(0, 32'h104, 2'd1);
    upd(32'h100, 1, 32'h200, 0); lit0(1, 32'h200, 2'd2);
    upd(32'h100, 1, 32'h200, 0); lit0(1, 32'h200, 2'd3);
    upd(32'h100, 0, 32'h0,   0); lit0(1, 32'h200, 2'd3);
    upd(32'h100, 0, 32'h0,   0); lit0(1, 32'h200, 2'd2);
    upd(32'h100, 0, 32'h0,   0); lit0(0, 32'h104, 2'd1);
    upd(32'h100, 1, 32'h200, 0); lit0(0, 32'h104, 2'd0);
    upd(32'h100, 1, 32'h200, 0); lit0(0, 32'h104, 2'd1);
    lit0(1, 32'h200, 2'd2);

    // Aliasing PC 0x140 (same index, tag 5) misses, then evicts.
    pc_fetch = 32'h140; upd(32'h140, 1, 32'h300, 0); lit0(0, 32'h144, 2'd1);
    pc_fetch = 32'h100; lit0(0, 32'h104, 2'd1);
    pc_fetch = 32'h140; upd(32'h180, 0, 32'hDEAD, 0); lit0(1, 32'h300, 2'd2);
    resolved_pc = 32'h140; resolved_taken = 1; resolved_target = 32'hBAD0; lit0(1, 32'h300, 2'd2);

    // Clear wins over a same-cycle update.
    clear = 1'b1; upd(32'h140, 1, 32'h999, 0); lit0(1, 32'h300, 2'd2);
    lit0(0, 32'h144, 2'd1);

    // Gshare history: taken, taken, not-taken -> ghr 6; 0x100 trained at index 0^6.
    pc_fetch = 32'h100;
    upd(32'h100, 1, 32'h500, 4'd6); cyc(1'b1, -1, 0, 0, 0, 0);
    upd(32'h800, 1, 32'h600, 4'd0); cyc(1'b1, -1, 0, 0, 0, 0);
    upd(32'h900, 0, 32'h700, 4'd0); cyc(1'b1, -1, 0, 0, 0, 0);
    cyc(1'b1, 1, 1, 32'h500, 2'd2, 4'd6);

    // Reset discards a same-cycle update.
    rst = 1'b1; upd(32'h100, 1, 32'h200, 0); cyc(1'b1, -1, 0, 0, 0, 0);
    lit0(0, 32'h104, 2'd1);
    cyc(1'b1, 1, 0, 32'h104, 2'd1, 4'd0);

    for (int n = 0; n < 600; n++) begin
      pc_fetch = ($urandom_range(0, 1) << 20) | ($urandom_range(4, 6) << 6) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 99) < 60)
        upd(($urandom_range(0, 1) << 20) | ($urandom_range(4, 6) << 6) | ($urandom_range(0, 15) << 2),
            1'($urandom_range(0, 99) < 60), $urandom, 4'($urandom));
      clear = ($urandom_range(0, 99) < 2);
      rst   = ($urandom_range(0, 99) < 1);
      cyc(1'b1, -1, 0, 0, 0, 0);
    end

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter ENTRIES, default 16, table depth; power of two, >= 4; IDX = log2(ENTRIES).
REQ-003 SHALL have parameter CTR_BITS, default 2, saturating counter width (2..4).
REQ-004 SHALL have parameter TAG_BITS, default 8, stored tag width.
REQ-005 SHALL have parameter MODE, default 0, index mode: 0 = bimodal, 1 = gshare.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port pc_fetch  input  XLEN  fetch-stage PC for lookup.
REQ-009 SHALL have port predict_taken  output  1  predicted taken.
REQ-010 SHALL have port predict_target  output  XLEN  next PC: stored target if predict_taken, else pc_fetch+4.
REQ-011 SHALL have port predict_state  output  CTR_BITS  counter value read at lookup (hit), else WNT.
REQ-012 SHALL have port predict_ghr  output  IDX  GHR value used for this lookup; carried down the pipeline.
REQ-013 SHALL have port update_en  input  1  one resolved branch this cycle.
REQ-014 SHALL have port resolved_pc  input  XLEN  PC of resolved branch.
REQ-015 SHALL have port resolved_taken  input  1  actual outcome.
REQ-016 SHALL have port resolved_target  input  XLEN  actual taken target.
REQ-017 SHALL have port resolved_ghr  input  IDX  predict_ghr captured at fetch of that branch.
REQ-018 SHALL have port clear  input  1  synchronous invalidate of all entries and GHR.

Function
REQ-019 Entry SHALL hold valid, tag[TAG_BITS], target[XLEN], ctr[CTR_BITS]; WNT = 2^(CTR_BITS-1)-1, WT = 2^(CTR_BITS-1).
REQ-020 Fetch index SHALL be pc_fetch[IDX+1:2] in MODE 0, pc_fetch[IDX+1:2] XOR ghr in MODE 1; tag = pc[IDX+TAG_BITS+1:IDX+2].
REQ-021 Update index SHALL use resolved_pc with resolved_ghr (MODE 1), never the current ghr.
REQ-022 Lookup SHALL be combinational from registered state, zero-cycle latency; hit = valid AND tag match.
REQ-023 predict_taken SHALL be hit AND ctr MSB; miss SHALL give predict_taken 0, predict_state WNT.
REQ-024 Update, hit entry: ctr SHALL saturate-increment on taken, saturate-decrement on not-taken; target overwritten only when taken.
REQ-025 Update, miss, taken: entry SHALL be allocated/overwritten: valid 1, new tag, resolved_target, ctr WT.
REQ-026 Update, miss, not-taken: table SHALL be unchanged.
REQ-027 MODE 1: every update SHALL shift ghr <= {ghr[IDX-2:0], resolved_taken}; MODE 0 ghr SHALL stay 0.
REQ-028 Update writes SHALL become visible the cycle after update_en; same-cycle lookup of the same entry SHALL return pre-update values.
REQ-029 Counter update SHALL read-modify-write the table's current ctr; predict_state is informational only.
REQ-030 Priority SHALL be rst > clear > update_en; clear SHALL zero all valid bits and ghr, leave ctr/target don't-care.
REQ-031 Inputs resolved_* SHALL be ignored when update_en is 0.

Reset
REQ-032 On rst: all valid 0, all ctr WNT, ghr 0; thus predict_taken 0, predict_target pc_fetch+4, predict_state WNT, predict_ghr 0 in the following cycle.
REQ-033 Reset asserted mid-operation SHALL discard any same-cycle update.

Verification (defaults, MODE 0 unless stated)
REQ-034 After rst, pc_fetch 0x100 -> taken 0, target 0x104, state 01.
REQ-035 Update 0x100 taken->0x200; next cycle fetch 0x100 -> taken 1, target 0x200, state 10; second taken update -> state 11; third -> stays 11.
REQ-036 From state 11, two not-taken updates -> state 01, taken 0, target 0x104; further not-taken -> 00, entry still valid.
REQ-037 Trained 0x100; fetch 0x140 (same index 0, tag 5 vs 4) -> miss, taken 0; taken update at 0x140->0x300 evicts 0x100 entry.
REQ-038 update_en and fetch of 0x100 same cycle -> old prediction shown; clear asserted with update -> all miss next cycle, ghr 0.
REQ-039 MODE 1: updates taken,taken,not-taken from ghr 0 -> ghr 0b0110; fetch 0x100 uses index 0^0b0110 = 6.
